// File: rtl/scan_io_harness.sv
// Serial scan harness: captures a DUT output bus into a shift register, shifts it out
// LSB-first at tester pace, and loads shifted-in data into a separate update register.
module scan_io_harness #(
   parameter int              IN_W      = 111,
   parameter int              OUT_W     = 111,
   parameter logic [IN_W-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             abort,
   input  logic             step,
   input  logic             si,
   output logic             so,
   output logic             busy,
   output logic             done,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out
);

   localparam int L  = (IN_W > OUT_W) ? IN_W : OUT_W;
   localparam int CW = $clog2(L + 1);
   localparam logic [CW-1:0] LAST = CW'(L - 1);

   localparam logic [1:0] OP_CAPTURE = 2'b00;
   localparam logic [1:0] OP_SHIFT   = 2'b01;
   localparam logic [1:0] OP_UPDATE  = 2'b10;
   localparam logic [1:0] OP_CSU     = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CAP   = 2'b01,
      S_SHIFT = 2'b10,
      S_UPD   = 2'b11
   } state_t;

   state_t          state;
   logic [L-1:0]    sr;
   logic [L-1:0]    sr_shifted;
   logic [IN_W-1:0] upd;
   logic [CW-1:0]   cnt;
   logic [1:0]      op_r;
   logic            done_r;

   // Written as shift-then-insert so that a one-bit register (L == 1) is still legal.
   always_comb begin
      sr_shifted        = sr >> 1;
      sr_shifted[L-1]   = si;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= S_IDLE;
         sr     <= '0;
         upd    <= RESET_VAL;
         cnt    <= '0;
         op_r   <= OP_CAPTURE;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (abort) begin
            // Partial shift data is kept in sr; the update register is left alone.
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cmd_valid) begin
                     op_r <= cmd_op;
                     case (cmd_op)
                        OP_SHIFT: begin
                           state <= S_SHIFT;
                           cnt   <= '0;
                        end
                        OP_UPDATE: state <= S_UPD;
                        default:   state <= S_CAP;
                     endcase
                  end
               end
               S_CAP: begin
                  sr[OUT_W-1:0] <= dut_out;
                  if (op_r == OP_CSU) begin
                     state <= S_SHIFT;
                     cnt   <= '0;
                  end else begin
                     state  <= S_IDLE;
                     done_r <= 1'b1;
                  end
               end
               S_SHIFT: begin
                  if (step) begin
                     sr  <= sr_shifted;
                     cnt <= cnt + CW'(1);
                     if (cnt == LAST) begin
                        if (op_r == OP_CSU) begin
                           state <= S_UPD;
                        end else begin
                           state  <= S_IDLE;
                           done_r <= 1'b1;
                        end
                     end
                  end
               end
               S_UPD: begin
                  upd    <= sr[IN_W-1:0];
                  state  <= S_IDLE;
                  done_r <= 1'b1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = done_r;
   assign so        = sr[0];
   assign dut_in    = upd;

endmodule
